// File: rtl/alu_wrap_if.sv
// alu_wrap_if: execute-stage ALU bus.
//   a, b, imm  operands and immediate from decode (WIDTH bits)
//   opcode     5-bit instruction opcode
//   out        combinational ALU result (WIDTH bits)
//   flags      registered {N,Z} branch flags
// The master modport belongs to the decode side that drives operands.
// The slave modport belongs to the ALU front end.
interface alu_wrap_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] out;
  logic [1:0]       flags;

  modport master (
    output a, b, imm, opcode,
    input  out, flags
  );

  modport slave (
    input  a, b, imm, opcode,
    output out, flags
  );
endinterface

// File: rtl/alu_wrap.sv
// alu_wrap: execute-stage ALU front end for the 5-bit-opcode CPU.
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high; clears flags only
//   bus  alu_wrap_if slave port with these signals:
//          a, b, imm, opcode  inputs
//          out                combinational result, with no reset value
//          flags              registered {N,Z}
// The opcode is decoded into a 3-bit ALU op and an operand-B select.
// The op drives the ALU core instance ALU.
// flags update only for the arithmetic, logic and compare opcodes.

// alu_core: purely combinational 3-bit-op ALU.
//   op  ALU operation; a, b  operands; y  result.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a * b;
      // Divide by zero saturates to all ones instead of being left undefined.
      3'd3: y = (b == '0) ? '1 : a / b;
      3'd4: y = a & b;
      3'd5: y = a | b;
      3'd6: y = a ^ b;
      3'd7: y = ~a;
      default: y = '0;
    endcase
  end
endmodule

module alu_wrap #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_wrap_if.slave bus
);
  typedef enum logic [2:0] {
    ADDA = 3'd0,
    SUBA = 3'd1,
    MULA = 3'd2,
    DIVA = 3'd3,
    ANDA = 3'd4,
    ORA  = 3'd5,
    XORA = 3'd6,
    NOTA = 3'd7
  } alu_op_e;

  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_ADDI  = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_SUBI  = 5'b00101;
  localparam logic [4:0] OP_MUL   = 5'b00110;
  localparam logic [4:0] OP_MOVEH = 5'b00111;
  localparam logic [4:0] OP_DIV   = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01010;
  localparam logic [4:0] OP_ANDI  = 5'b01011;
  localparam logic [4:0] OP_OR    = 5'b01100;
  localparam logic [4:0] OP_ORI   = 5'b01101;
  localparam logic [4:0] OP_NOT   = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b10000;
  localparam logic [4:0] OP_XORI  = 5'b10001;
  localparam logic [4:0] OP_CMP   = 5'b10010;
  localparam logic [4:0] OP_ST    = 5'b11100;
  localparam logic [4:0] OP_LD    = 5'b11101;
  localparam logic [4:0] OP_MOVEL = 5'b11110;

  alu_op_e          alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flag_en;
  logic [WIDTH-1:0] result;

  // Decode: unlisted opcodes (CALL/RET/RETI/unused) fall through to a+0.
  // That passes a straight through and leaves the flags untouched.
  // MOVEH/MOVEL reuse the AND path with an all-ones mask to forward imm.
  always_comb begin
    alu_op  = ADDA;
    op_a    = bus.a;
    op_b    = '0;
    flag_en = 1'b0;
    case (bus.opcode)
      OP_ADD:   begin alu_op = ADDA; op_b = bus.b;   flag_en = 1'b1; end
      OP_ADDI:  begin alu_op = ADDA; op_b = bus.imm; flag_en = 1'b1; end
      OP_SUB:   begin alu_op = SUBA; op_b = bus.b;   flag_en = 1'b1; end
      OP_SUBI:  begin alu_op = SUBA; op_b = bus.imm; flag_en = 1'b1; end
      OP_MUL:   begin alu_op = MULA; op_b = bus.b;   flag_en = 1'b1; end
      OP_DIV:   begin alu_op = DIVA; op_b = bus.b;   flag_en = 1'b1; end
      OP_AND:   begin alu_op = ANDA; op_b = bus.b;   flag_en = 1'b1; end
      OP_ANDI:  begin alu_op = ANDA; op_b = bus.imm; flag_en = 1'b1; end
      OP_OR:    begin alu_op = ORA;  op_b = bus.b;   flag_en = 1'b1; end
      OP_ORI:   begin alu_op = ORA;  op_b = bus.imm; flag_en = 1'b1; end
      OP_XOR:   begin alu_op = XORA; op_b = bus.b;   flag_en = 1'b1; end
      OP_XORI:  begin alu_op = XORA; op_b = bus.imm; flag_en = 1'b1; end
      OP_NOT:   begin alu_op = NOTA; op_b = bus.b;   flag_en = 1'b1; end
      OP_CMP:   begin alu_op = SUBA; op_b = bus.b;   flag_en = 1'b1; end
      OP_LD,
      OP_ST:    begin alu_op = ADDA; op_b = bus.imm; end
      OP_MOVEH,
      OP_MOVEL: begin alu_op = ANDA; op_a = bus.imm; op_b = '1; end
      default:  begin alu_op = ADDA; op_b = '0; end
    endcase
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) ALU (
    .op (alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (result)
  );

  assign bus.out = result;

  // {N,Z} flags register; holds its value for non-flag-setting opcodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flags <= 2'b00;
    end else if (flag_en) begin
      bus.flags <= {result[WIDTH-1], (result == '0)};
    end
  end
endmodule

// File: tb/tb_alu_wrap.sv
// tb_alu_wrap: self-checking bench for alu_wrap.
// Uses directed steps plus random operand sweeps.
// Results are compared against a behavioural opcode-level reference model.
module tb_alu_wrap;
  localparam logic [4:0] ADD   = 5'b00010;
  localparam logic [4:0] ADDI  = 5'b00011;
  localparam logic [4:0] SUB   = 5'b00100;
  localparam logic [4:0] SUBI  = 5'b00101;
  localparam logic [4:0] MUL   = 5'b00110;
  localparam logic [4:0] MOVEH = 5'b00111;
  localparam logic [4:0] DIV   = 5'b01000;
  localparam logic [4:0] AND_  = 5'b01010;
  localparam logic [4:0] ANDI  = 5'b01011;
  localparam logic [4:0] OR_   = 5'b01100;
  localparam logic [4:0] ORI   = 5'b01101;
  localparam logic [4:0] NOT_  = 5'b01110;
  localparam logic [4:0] XOR_  = 5'b10000;
  localparam logic [4:0] XORI  = 5'b10001;
  localparam logic [4:0] CMP   = 5'b10010;
  localparam logic [4:0] ST    = 5'b11100;
  localparam logic [4:0] LD    = 5'b11101;
  localparam logic [4:0] MOVEL = 5'b11110;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic [1:0] exp_flags = 2'b00;

  alu_wrap_if #(.WIDTH(32)) bus ();

  alu_wrap #(
    .WIDTH(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference result straight from the instruction semantics.
  function automatic logic [31:0] model_out(logic [4:0] opc, logic [31:0] a, logic [31:0] b,
                                            logic [31:0] imm);
    logic [63:0] prod;
    case (opc)
      ADD:         return a + b;
      ADDI:        return a + imm;
      SUB, CMP:    return a - b;
      SUBI:        return a - imm;
      MUL: begin
        prod = 64'(a) * 64'(b);
        return prod[31:0];
      end
      DIV:         return (b == 0) ? 32'hFFFF_FFFF : a / b;
      AND_:        return a & b;
      ANDI:        return a & imm;
      OR_:         return a | b;
      ORI:         return a | imm;
      XOR_:        return a ^ b;
      XORI:        return a ^ imm;
      NOT_:        return ~a;
      LD, ST:      return a + imm;
      MOVEH, MOVEL: return imm;
      default:     return a;
    endcase
  endfunction

  // Expected ALU op per opcode, taken from the decode table.
  function automatic logic [2:0] exp_op(logic [4:0] opc);
    case (opc)
      SUB, SUBI, CMP:          return 3'b001;
      MUL:                     return 3'b010;
      DIV:                     return 3'b011;
      AND_, ANDI, MOVEH, MOVEL: return 3'b100;
      OR_, ORI:                return 3'b101;
      XOR_, XORI:              return 3'b110;
      NOT_:                    return 3'b111;
      default:                 return 3'b000;
    endcase
  endfunction

  function automatic bit sets_flags(logic [4:0] opc);
    case (opc)
      ADD, ADDI, SUB, SUBI, MUL, DIV, AND_, ANDI, OR_, ORI, XOR_, XORI, NOT_, CMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one instruction on the falling edge, then let the combinational output settle.
  task automatic applyStimulus(logic [4:0] opc, logic [31:0] av, logic [31:0] bv,
                               logic [31:0] iv);
    @(negedge clk);
    bus.opcode = opc;
    bus.a      = av;
    bus.b      = bv;
    bus.imm    = iv;
    #1;
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One full instruction: check out and ALU.op, clock it, then check flags.
  task automatic runStep(string tag, logic [4:0] opc, logic [31:0] av, logic [31:0] bv,
                         logic [31:0] iv);
    logic [31:0] m;
    m = model_out(opc, av, bv, iv);
    applyStimulus(opc, av, bv, iv);
    checkOutput({tag, "_out"}, bus.out, m);
    checkOutput({tag, "_op"}, {29'b0, dut.ALU.op}, {29'b0, exp_op(opc)});
    @(posedge clk);
    #1;
    if (sets_flags(opc)) exp_flags = {m[31], m == 0};
    checkOutput({tag, "_flags"}, {30'b0, bus.flags}, {30'b0, exp_flags});
  endtask

  logic [4:0] sweep_ops [22] = '{ADD, ADDI, LD, ST, SUB, SUBI, CMP, MUL, DIV, AND_, ANDI,
                                 MOVEH, MOVEL, OR_, ORI, XOR_, XORI, NOT_,
                                 5'b00000, 5'b00001, 5'b11111, 5'b10100};

  initial begin
    // Reset phase: flags are cleared, and out still follows its inputs.
    rst        = 1'b1;
    bus.opcode = ADD;
    bus.a      = 32'd3;
    bus.b      = 32'd4;
    bus.imm    = 32'd0;
    #12;
    checkOutput("reset_flags", {30'b0, bus.flags}, 32'd0);
    checkOutput("reset_out", bus.out, 32'd7);
    @(negedge clk);
    rst = 1'b0;

    // Decode sweep over every listed opcode, plus a few unlisted ones.
    foreach (sweep_ops[i])
      runStep("sweep", sweep_ops[i], $urandom, $urandom, $urandom);

    // ADD random sweep, followed by the wrap-to-zero edge case.
    for (int i = 0; i < 4095; i++) runStep("add_rand", ADD, $urandom, $urandom, $urandom);
    runStep("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    checkOutput("add_wrap_const_out", bus.out, 32'd0);
    checkOutput("add_wrap_const_flags", {30'b0, bus.flags}, 32'd1);

    // ADDI random sweep; b is random and must not matter.
    for (int i = 0; i < 4095; i++) runStep("addi_rand", ADDI, $urandom, $urandom, $urandom);

    // CMP results, then LD leaves the flags unchanged.
    runStep("cmp57", CMP, 32'd5, 32'd7, 32'd0);
    checkOutput("cmp57_const_out", bus.out, 32'hFFFF_FFFE);
    checkOutput("cmp57_const_flags", {30'b0, bus.flags}, 32'd2);
    runStep("cmp77", CMP, 32'd7, 32'd7, 32'd0);
    checkOutput("cmp77_const_flags", {30'b0, bus.flags}, 32'd1);
    runStep("ld_hold", LD, 32'h100, 32'd0, 32'h24);
    checkOutput("ld_const_flags", {30'b0, bus.flags}, 32'd1);
    checkOutput("ld_const_out", bus.out, 32'h124);

    // MUL and DIV cases.
    runStep("mul", MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
    checkOutput("mul_const_out", bus.out, 32'd0);
    runStep("div", DIV, 32'd100, 32'd7, 32'd0);
    checkOutput("div_const_out", bus.out, 32'd14);
    runStep("div0", DIV, 32'd1234, 32'd0, 32'd0);
    checkOutput("div0_const_out", bus.out, 32'hFFFF_FFFF);

    // Logic ops and MOVEL.
    runStep("and", AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    checkOutput("and_const_out", bus.out, 32'hF000_F000);
    runStep("or", OR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    checkOutput("or_const_out", bus.out, 32'hFFF0_FFF0);
    runStep("xor", XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    checkOutput("xor_const_out", bus.out, 32'h0FF0_0FF0);
    runStep("not", NOT_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    checkOutput("not_const_out", bus.out, 32'h0F0F_0F0F);
    runStep("movel", MOVEL, 32'hDEAD_BEEF, 32'd9, 32'h0000_1234);
    checkOutput("movel_const_out", bus.out, 32'h0000_1234);

    // Asynchronous reset pulse between clock edges, with flags set to 10 first.
    runStep("cmp_pre_rst", CMP, 32'd5, 32'd7, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_pulse_flags", {30'b0, bus.flags}, 32'd0);
    checkOutput("rst_pulse_out", bus.out, 32'hFFFF_FFFE);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_flags", {30'b0, bus.flags}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
